ttl_374_bank_sync: RTL and testbench

//  Parametrised bank of NCH independent WIDTH-bit edge-triggered registers (74LS374-class), clocked

---
 rtl/ttl_bank_pkg.sv | 30 +++
 rtl/ttl_strobe_edge_det.sv | 93 +++++++++
 rtl/ttl_374_bank_sync.sv | 127 ++++++++++++
 tb/tb_ttl_374_bank_sync.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/ttl_bank_pkg.sv
// ----------------------------------------------------------------------------
// ttl_bank_pkg
// Shared constants and types for the synchronous '374 register bank.
//   MAX_NCH     : largest supported channel count
//   MAX_SYNC    : largest supported resync depth on strobe/data
//   edge_mode_e : which strobe transition causes a capture
//   active_level: strobe level that counts as "active" for a given edge mode
// ----------------------------------------------------------------------------
package ttl_bank_pkg;

  localparam int MAX_NCH  = 16;
  localparam int MAX_SYNC = 3;

  typedef enum logic {
    EDGE_FALL = 1'b0,
    EDGE_RISE = 1'b1
  } edge_mode_e;

  // Level the strobe sits at once the capturing transition has happened.
  function automatic logic active_level(input edge_mode_e mode);
    logic lvl;
    case (mode)
      EDGE_RISE: lvl = 1'b1;
      EDGE_FALL: lvl = 1'b0;
      default:   lvl = 1'b1;
    endcase
    return lvl;
  endfunction

endpackage

// File: rtl/ttl_strobe_edge_det.sv
// ----------------------------------------------------------------------------
// ttl_strobe_edge_det
// One channel's strobe front end: optional resync pipeline on strobe and
// data (kept in lockstep), strobe history flop, edge detector and the
// registered capture pulse.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-high reset
//   cen      in   raw channel strobe (level)
//   d        in   raw channel data, WIDTH bits
//   edge_det out  1 in the clock where the register must capture
//   d_sync   out  data delayed by the same number of stages as the strobe
//   cap_pls  out  edge_det delayed by one clock
// ----------------------------------------------------------------------------
module ttl_strobe_edge_det
  import ttl_bank_pkg::*;
#(
  parameter int         WIDTH    = 8,
  parameter int         SYNC_STG = 0,
  parameter edge_mode_e MODE     = EDGE_RISE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic [WIDTH-1:0] d,
  output logic             edge_det,
  output logic [WIDTH-1:0] d_sync,
  output logic             cap_pls
);

  // History resets to the active level: a strobe already active when reset
  // lets go must first go inactive before it can capture.
  localparam logic ACT_LVL = active_level(MODE);

  logic cen_s;
  logic hist_r;
  logic cap_pls_r;

  generate
    if (SYNC_STG == 0) begin : g_nosync
      assign cen_s  = cen;
      assign d_sync = d;
    end else begin : g_sync
      logic [SYNC_STG-1:0] cen_pipe_r;
      logic [WIDTH-1:0]    d_pipe_r [SYNC_STG];

      // Strobe and data shift through identical depths so the data seen at
      // the edge is the data that accompanied the strobe at the pin.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          cen_pipe_r <= '0;
          for (int k = 0; k < SYNC_STG; k++) begin
            d_pipe_r[k] <= '0;
          end
        end else begin
          cen_pipe_r[0] <= cen;
          d_pipe_r[0]   <= d;
          for (int k = 1; k < SYNC_STG; k++) begin
            cen_pipe_r[k] <= cen_pipe_r[k-1];
            d_pipe_r[k]   <= d_pipe_r[k-1];
          end
        end
      end

      assign cen_s  = cen_pipe_r[SYNC_STG-1];
      assign d_sync = d_pipe_r[SYNC_STG-1];
    end
  endgenerate

  // Edge decode against the previous clock's synchronised strobe.
  always_comb begin
    edge_det = 1'b0;
    if (MODE == EDGE_RISE) begin
      edge_det = cen_s & ~hist_r;
    end else begin
      edge_det = ~cen_s & hist_r;
    end
  end

  // Strobe history and the one-clock capture pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_r    <= ACT_LVL;
      cap_pls_r <= 1'b0;
    end else begin
      hist_r    <= cen_s;
      cap_pls_r <= edge_det;
    end
  end

  assign cap_pls = cap_pls_r;

endmodule

// File: rtl/ttl_374_bank_sync.sv
// ----------------------------------------------------------------------------
// ttl_374_bank_sync
// Bank of NCH independent WIDTH-bit '374-style registers, all clocked on Clk.
// Each channel captures its D on a detected edge of its own strobe Cen.
// Optional feature macro: TTL_BANK_CAPTURE_FLAG_EN (adds ack/new_flag/ovr_flag).
// Ports:
//   Clk      in   system clock
//   RESET    in   asynchronous active-high reset
//   Cen      in   NCH      per-channel capture strobe (level)
//   OCn      in   NCH      per-channel output enable, active low
//   D        in   NCH*W    channel data, channel i at [i*WIDTH +: WIDTH]
//   Q        out  NCH*W    channel outputs (FLOAT_VAL while disabled)
//   cap_pls  out  NCH      high in the cycle the newly captured value shows
//   ack      in   NCH      (flag build) clears new_flag / ovr_flag
//   new_flag out  NCH      (flag build) unread capture pending
//   ovr_flag out  NCH      (flag build) capture overwrote an unread value
// ----------------------------------------------------------------------------
module ttl_374_bank_sync
  import ttl_bank_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter int               NCH       = 4,
  parameter int               EDGE_RISE = 1,
  parameter int               SYNC_STG  = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLOAT_VAL = '1
) (
  input  logic                 Clk,
  input  logic                 RESET,
  input  logic [NCH-1:0]       Cen,
  input  logic [NCH-1:0]       OCn,
  input  logic [NCH*WIDTH-1:0] D,
  output logic [NCH*WIDTH-1:0] Q,
  output logic [NCH-1:0]       cap_pls
`ifdef TTL_BANK_CAPTURE_FLAG_EN
  ,
  input  logic [NCH-1:0]       ack,
  output logic [NCH-1:0]       new_flag,
  output logic [NCH-1:0]       ovr_flag
`endif
);

  // Local parameter EDGE_RISE hides the enum literal, so name it by scope.
  localparam edge_mode_e MODE = (EDGE_RISE != 0) ? ttl_bank_pkg::EDGE_RISE
                                                 : ttl_bank_pkg::EDGE_FALL;

  logic [NCH-1:0]   edge_s;
  logic [WIDTH-1:0] d_sync_s  [NCH];
  logic [WIDTH-1:0] cap_reg_r [NCH];

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      ttl_strobe_edge_det #(
        .WIDTH    (WIDTH),
        .SYNC_STG (SYNC_STG),
        .MODE     (MODE)
      ) u_edge (
        .clk      (Clk),
        .rst      (RESET),
        .cen      (Cen[i]),
        .d        (D[i*WIDTH +: WIDTH]),
        .edge_det (edge_s[i]),
        .d_sync   (d_sync_s[i]),
        .cap_pls  (cap_pls[i])
      );

      // The '374 register itself: loads only on a detected strobe edge.
      always_ff @(posedge Clk or posedge RESET) begin
        if (RESET) begin
          cap_reg_r[i] <= RESET_VAL;
        end else if (edge_s[i]) begin
          cap_reg_r[i] <= d_sync_s[i];
        end else begin
          cap_reg_r[i] <= cap_reg_r[i];
        end
      end
    end
  endgenerate

  // Output enable acts on the pins only; a disabled channel reads as the
  // pulled-up bus value rather than tri-state.
  always_comb begin
    Q = '0;
    for (int i = 0; i < NCH; i++) begin
      if (OCn[i]) begin
        Q[i*WIDTH +: WIDTH] = FLOAT_VAL;
      end else begin
        Q[i*WIDTH +: WIDTH] = cap_reg_r[i];
      end
    end
  end

`ifdef TTL_BANK_CAPTURE_FLAG_EN
  logic [NCH-1:0] new_flag_r;
  logic [NCH-1:0] ovr_flag_r;

  // Capture wins over ack for new_flag; overrun clears only on a clean ack.
  always_ff @(posedge Clk or posedge RESET) begin
    if (RESET) begin
      new_flag_r <= '0;
      ovr_flag_r <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (edge_s[i]) begin
          new_flag_r[i] <= 1'b1;
        end else if (ack[i]) begin
          new_flag_r[i] <= 1'b0;
        end else begin
          new_flag_r[i] <= new_flag_r[i];
        end

        if (edge_s[i] && new_flag_r[i]) begin
          ovr_flag_r[i] <= 1'b1;
        end else if (ack[i] && !edge_s[i]) begin
          ovr_flag_r[i] <= 1'b0;
        end else begin
          ovr_flag_r[i] <= ovr_flag_r[i];
        end
      end
    end
  end

  assign new_flag = new_flag_r;
  assign ovr_flag = ovr_flag_r;
`endif

endmodule

// File: tb/tb_ttl_374_bank_sync.sv
// ----------------------------------------------------------------------------
// tb_ttl_374_bank_sync
// Directed bench for ttl_374_bank_sync. dut0: default build (8x4, rising,
// no resync). dut1: SYNC_STG=2, falling-edge capture. Flag checks are built
// only when TTL_BANK_CAPTURE_FLAG_EN is defined.
// ----------------------------------------------------------------------------
module tb_ttl_374_bank_sync;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cen0, ocn0, cen1, ocn1;
  logic [31:0] d0, d1, q0, q1;
  logic [3:0]  cap0, cap1;
`ifdef TTL_BANK_CAPTURE_FLAG_EN
  logic [3:0]  ack0, ack1, nf0, of0, nf1, of1;
`endif

  int vectors     = 0;
  int miscompares = 0;
  logic [7:0] qexp;

  always #5 clk = ~clk;

  ttl_374_bank_sync #(
    .WIDTH(8), .NCH(4), .EDGE_RISE(1), .SYNC_STG(0)
  ) dut0 (
    .Clk(clk), .RESET(rst), .Cen(cen0), .OCn(ocn0), .D(d0), .Q(q0), .cap_pls(cap0)
`ifdef TTL_BANK_CAPTURE_FLAG_EN
    , .ack(ack0), .new_flag(nf0), .ovr_flag(of0)
`endif
  );

  ttl_374_bank_sync #(
    .WIDTH(8), .NCH(4), .EDGE_RISE(0), .SYNC_STG(2)
  ) dut1 (
    .Clk(clk), .RESET(rst), .Cen(cen1), .OCn(ocn1), .D(d1), .Q(q1), .cap_pls(cap1)
`ifdef TTL_BANK_CAPTURE_FLAG_EN
    , .ack(ack1), .new_flag(nf1), .ovr_flag(of1)
`endif
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    cen0 = 4'b0010;          // ch1 strobe held active through reset
    ocn0 = 4'b0000;
    d0   = 32'h0;
    cen1 = 4'b1000;          // falling mode: ch3 inactive, ch0..2 held active
    ocn1 = 4'b0000;
    d1   = 32'h0;
`ifdef TTL_BANK_CAPTURE_FLAG_EN
    ack0 = 4'b0;
    ack1 = 4'b0;
`endif
    tick();
    tick();
    check_val("rst_q0", q0, 32'h0);
    check_val("rst_cap0", {28'h0, cap0}, 32'h0);
    check_val("rst_q1", q1, 32'h0);
    check_val("rst_cap1", {28'h0, cap1}, 32'h0);

    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      check_val("rel_q0", q0, 32'h0);
      check_val("rel_cap0", {28'h0, cap0}, 32'h0);
      check_val("rel_q1", q1, 32'h0);
      check_val("rel_cap1", {28'h0, cap1}, 32'h0);
    end

    // basic rising capture on ch0
    d0[7:0] = 8'hA5;
    cen0[0] = 1'b1;
    tick();
    check_val("t1_q", {24'h0, q0[7:0]}, 32'hA5);
    check_val("t1_cap", {28'h0, cap0}, 32'h1);
    tick();
    check_val("t1_cap_end", {28'h0, cap0}, 32'h0);
    check_val("t1_q_hold", {24'h0, q0[7:0]}, 32'hA5);

    // ch1: drop then raise after having been active through reset
    cen0[1] = 1'b0;
    d0[15:8] = 8'h5A;
    tick();
    check_val("t2_nocap", {24'h0, q0[15:8]}, 32'h0);
    cen0[1] = 1'b1;
    tick();
    check_val("t2_q", {24'h0, q0[15:8]}, 32'h5A);
    check_val("t2_cap", {28'h0, cap0}, 32'h2);

    // output enable on ch2
    d0[23:16] = 8'h3C;
    cen0[2] = 1'b1;
    tick();
    check_val("t3_q", {24'h0, q0[23:16]}, 32'h3C);
    ocn0[2] = 1'b1;
    #1;
    check_val("t3_float", {24'h0, q0[23:16]}, 32'hFF);
    check_val("t3_others", {16'h0, q0[15:0]}, 32'h5AA5);
    tick();
    d0[23:16] = 8'h77;
    tick();
    ocn0[2] = 1'b0;
    #1;
    check_val("t3_reenable", {24'h0, q0[23:16]}, 32'h3C);
    check_val("t3_nocap", {28'h0, cap0}, 32'h0);

    // all four channels in one clock
    cen0 = 4'b0000;
    tick();
    d0   = 32'h44332211;
    cen0 = 4'b1111;
    tick();
    check_val("t5_q", q0, 32'h44332211);
    check_val("t5_cap", {28'h0, cap0}, 32'hF);
    tick();
    check_val("t5_cap_end", {28'h0, cap0}, 32'h0);

    // ch0 strobe toggling every clock: capture on every rising step only
    qexp = 8'h11;
    for (int k = 0; k < 6; k++) begin
      cen0[0] = ~cen0[0];
      d0[7:0] = 8'h10 + 8'(k);
      if (cen0[0]) qexp = 8'h10 + 8'(k);
      tick();
      check_val("tog_cap", {31'h0, cap0[0]}, {31'h0, cen0[0]});
      check_val("tog_q", {24'h0, q0[7:0]}, {24'h0, qexp});
    end

    // dut1: falling edge through two resync stages, data aligned
    d1[31:24] = 8'h81;
    cen1[3]   = 1'b0;
    tick();
    check_val("t4_p1", {24'h0, q1[31:24]}, 32'h0);
    d1[31:24] = 8'h99;
    tick();
    check_val("t4_p2", {24'h0, q1[31:24]}, 32'h0);
    check_val("t4_p2_cap", {28'h0, cap1}, 32'h0);
    tick();
    check_val("t4_p3", {24'h0, q1[31:24]}, 32'h81);
    check_val("t4_p3_cap", {28'h0, cap1}, 32'h8);
    tick();
    check_val("t4_cap_end", {28'h0, cap1}, 32'h0);
    check_val("t4_other_ch", {8'h0, q1[23:0]}, 32'h0);

    // reset while an edge is still in the resync pipe
    cen1[3] = 1'b1;
    tick();
    tick();
    tick();
    d1[31:24] = 8'h42;
    cen1[3]   = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check_val("mid_q1", q1, 32'h0);
    check_val("mid_q0", q0, 32'h0);
    check_val("mid_cap0", {28'h0, cap0}, 32'h0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("mid_post_cap1", {28'h0, cap1}, 32'h0);
      check_val("mid_post_q1", {24'h0, q1[31:24]}, 32'h0);
      check_val("mid_post_cap0", {28'h0, cap0}, 32'h0);
    end

`ifdef TTL_BANK_CAPTURE_FLAG_EN
    cen0 = 4'b0000;
    tick();
    cen0[0] = 1'b1;
    tick();
    check_val("fl_new1", {30'h0, of0[0], nf0[0]}, 32'h1);
    cen0[0] = 1'b0;
    tick();
    cen0[0] = 1'b1;
    tick();
    check_val("fl_ovr", {30'h0, of0[0], nf0[0]}, 32'h3);
    cen0[0] = 1'b0;
    tick();
    cen0[0] = 1'b1;
    ack0[0] = 1'b1;
    tick();
    check_val("fl_ack_cap", {30'h0, of0[0], nf0[0]}, 32'h3);
    cen0[0] = 1'b0;
    tick();
    check_val("fl_ack_clr", {30'h0, of0[0], nf0[0]}, 32'h0);
    ack0 = 4'b0010;
    tick();
    check_val("fl_ack_idle", {28'h0, nf0 | of0}, 32'h0);
    ack0 = 4'b0000;
    cen0[0] = 1'b1;
    tick();
    check_val("fl_cap_again", {30'h0, cap0[0], nf0[0]}, 32'h3);
    rst = 1'b1;
    #1;
    check_val("fl_rst_flags", {24'h0, of0, nf0}, 32'h0);
    check_val("fl_rst_cap", {28'h0, cap0}, 32'h0);
    check_val("fl_rst_q", q0, 32'h0);
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
